// File: rtl/adder_slice.sv
// One CH-bit ripple chain of full-adder cells; purely combinational.
// The parent pipeline owns every register around it.
module adder_slice #(
  parameter int unsigned CH = 4
) (
  input  logic [CH-1:0] a_i,
  input  logic [CH-1:0] b_i,
  input  logic          ci_i,
  output logic [CH-1:0] s_o,
  output logic          co_o
);

  logic [CH:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < CH; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = c[CH];
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple slices with a registered carry
// between them, operand skew / sum deskew registers, and a valid/ready handshake.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int unsigned CH   = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  if (WIDTH % STAGES != 0) begin : gen_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [STAGES-1:0] v_q, v_in, sa_q, sa_in, sb_q, sb_in, carry;

  // One enable freezes the whole pipeline while a result waits downstream.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = B ^ {WIDTH{SUB}};
  assign c0       = SUB | Cin;

  always_comb begin
    v_in     = '0;
    sa_in    = '0;
    sb_in    = '0;
    v_in[0]  = in_valid;
    sa_in[0] = A[WIDTH-1];
    sb_in[0] = b_eff[WIDTH-1];
    for (int j = 1; j < STAGES; j++) begin
      v_in[j]  = v_q[j-1];
      sa_in[j] = sa_q[j-1];
      sb_in[j] = sb_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      sa_q <= '0;
      sb_q <= '0;
    end else if (en) begin
      v_q <= v_in;
      for (int j = 0; j < STAGES; j++) begin
        if (v_in[j]) begin
          sa_q[j] <= sa_in[j];
          sb_q[j] <= sb_in[j];
        end
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_slice
    localparam int unsigned Dsk = STAGES - 1 - k;

    logic [CH-1:0] a_k, b_k, s_k, s_q, s_out;
    logic          ci_k, co_k, c_q;

    if (k == 0) begin : gen_head
      assign a_k  = A[CH-1:0];
      assign b_k  = b_eff[CH-1:0];
      assign ci_k = c0;
    end else begin : gen_skew
      // Element j sits at pipeline position j, so slice k meets its carry at stage k.
      logic [CH-1:0] a_sk_q [k];
      logic [CH-1:0] b_sk_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_sk_q[j] <= '0;
            b_sk_q[j] <= '0;
          end
        end else if (en) begin
          if (v_in[0]) begin
            a_sk_q[0] <= A[k*CH +: CH];
            b_sk_q[0] <= b_eff[k*CH +: CH];
          end
          for (int j = 1; j < k; j++) begin
            if (v_in[j]) begin
              a_sk_q[j] <= a_sk_q[j-1];
              b_sk_q[j] <= b_sk_q[j-1];
            end
          end
        end
      end

      assign a_k  = a_sk_q[k-1];
      assign b_k  = b_sk_q[k-1];
      assign ci_k = carry[k-1];
    end

    adder_slice #(
      .CH(CH)
    ) u_slice (
      .a_i (a_k),
      .b_i (b_k),
      .ci_i(ci_k),
      .s_o (s_k),
      .co_o(co_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en && v_in[k]) begin
        s_q <= s_k;
        c_q <= co_k;
      end
    end

    assign carry[k] = c_q;

    if (Dsk == 0) begin : gen_nodesk
      assign s_out = s_q;
    end else begin : gen_desk
      logic [CH-1:0] ds_q [Dsk];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int m = 0; m < Dsk; m++) ds_q[m] <= '0;
        end else if (en) begin
          if (v_in[k+1]) ds_q[0] <= s_q;
          for (int m = 1; m < Dsk; m++) begin
            if (v_in[k+1+m]) ds_q[m] <= ds_q[m-1];
          end
        end
      end

      assign s_out = ds_q[Dsk-1];
    end

    assign S[k*CH +: CH] = s_out;
  end

  assign out_valid = v_q[Last];
  assign Cout      = carry[Last];
  assign OVF       = (sa_q[Last] == sb_q[Last]) && (S[WIDTH-1] != sa_q[Last]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES 4, 1, 16) share stimulus and are
// checked against an arithmetic model plus directed vectors and corner sequences.
module tb_pipelined_adder;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready, cin, sub;
  logic [W-1:0] a, b;
  logic         ir [3];
  logic         ov [3];
  logic [W-1:0] s  [3];
  logic         co [3];
  logic         of [3];

  int           stg [3] = '{4, 1, 16};
  logic [17:0]  exp_q [3][$];
  int           rx [3] = '{0, 0, 0};
  logic [17:0]  mon_e;
  int           n_checks = 0;
  int           n_fail = 0;
  vec_t         vecs [9];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .A(a), .B(b),
    .Cin(cin), .SUB(sub), .out_valid(ov[0]), .out_ready(out_ready), .S(s[0]),
    .Cout(co[0]), .OVF(of[0])
  );
  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .A(a), .B(b),
    .Cin(cin), .SUB(sub), .out_valid(ov[1]), .out_ready(out_ready), .S(s[1]),
    .Cout(co[1]), .OVF(of[1])
  );
  pipelined_adder #(.WIDTH(W), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .A(a), .B(b),
    .Cin(cin), .SUB(sub), .out_valid(ov[2]), .out_ready(out_ready), .S(s[2]),
    .Cout(co[2]), .OVF(of[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic: {S, Cout, OVF}.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic sb);
    int ux, uy, ur, sx, sy, sr;
    logic co_m, ov_m;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ur   = ux - uy;
      co_m = (ux >= uy);
      sr   = sx - sy;
    end else begin
      ur   = ux + uy + int'(ci);
      co_m = (ur > 65535);
      sr   = sx + sy + int'(ci);
    end
    ov_m = (sr > 32767) || (sr < -32768);
    return {ur[15:0], co_m, ov_m};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: outputs transfer / inputs accept on the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) exp_q[d].delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          check($sformatf("sb_entry_pending_d%0d", stg[d]), 32'(exp_q[d].size() != 0), 32'd1);
          if (exp_q[d].size() != 0) begin
            mon_e = exp_q[d].pop_front();
            check($sformatf("sb_result_d%0d", stg[d]), 32'({s[d], co[d], of[d]}), 32'(mon_e));
          end
          rx[d]++;
        end
        if (in_valid && ir[d]) exp_q[d].push_back(model(a, b, cin, sub));
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int          lat [3];
    logic [17:0] got [3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0;
      got[d] = '0;
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (lat[d] == 0 && ov[d]) begin
          lat[d] = n;
          got[d] = {s[d], co[d], of[d]};
        end
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_latency_d%0d", tag, stg[d]), 32'(lat[d]), 32'(stg[d]));
      check($sformatf("%s_result_d%0d", tag, stg[d]), 32'(got[d]),
            32'({v.s, v.cout, v.ovf}));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
  endtask

  initial begin
    int   i, st, base, cnt;
    logic acc;
    logic [W-1:0] held;
    vec_t v37;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    // Operands present during reset must not leak into the pipeline.
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_valid_d%0d", stg[d]), 32'(ov[d]), 32'd0);
      check($sformatf("rst_s_d%0d", stg[d]), 32'(s[d]), 32'd0);
      check($sformatf("rst_cout_ovf_d%0d", stg[d]), 32'({co[d], of[d]}), 32'd0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++)
      check($sformatf("rst_in_ready_d%0d", stg[d]), 32'(ir[d]), 32'd1);

    for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));
    drain("vectors");

    // Six back-to-back ops; stall the output for three cycles once results appear.
    out_ready = 1'b1; i = 1; st = 0; base = rx[0]; held = '0; acc = 1'b0;
    for (int cyc = 0; cyc < 80 && (rx[0] - base) < 6; cyc++) begin
      @(posedge clk); #1;
      if (acc) i++;
      if (st >= 1 && st <= 3) begin
        check("stall_in_ready", 32'(ir[0]), 32'd0);
        check("stall_s_hold", 32'(s[0]), 32'(held));
        check("stall_out_valid", 32'(ov[0]), 32'd1);
        st++;
        if (st == 4) out_ready = 1'b1;
      end else if (st == 0 && ov[0]) begin
        out_ready = 1'b0;
        held = s[0];
        st = 1;
      end
      if (i <= 6) begin
        in_valid = 1'b1; a = 16'(i); b = 16'(256 * i); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #3 acc = in_valid && ir[0];
    end
    in_valid = 1'b0;
    check("stall_rx_count", 32'(rx[0] - base), 32'd6);
    check("stall_happened", 32'(st), 32'd4);
    drain("stall");

    // Reset with two operations in flight.
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b1; a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1 a = 16'h0030; b = 16'h0040;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov[0]), 32'd0);
    check("midrst_s", 32'(s[0]), 32'd0);
    check("midrst_s16", 32'(s[2]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_in_ready", 32'(ir[0]), 32'd1);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov[0] || ov[1] || ov[2]) cnt++;
    end
    check("midrst_no_leak", 32'(cnt), 32'd0);
    v37 = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    run_vec(v37, "after_rst");
    drain("after_rst");

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a   = pick();
      b   = pick();
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
